// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment reader and the display driver.
// This file holds the segment patterns for digits 0-9, the blank pattern,
// the blank code, the reader FSM state encoding, and the decode helper.
// Segment bit order is bit6..bit0 = segments g..a.
package seg_pkg;

    localparam logic [6:0] PAT_0     = 7'b0111111;
    localparam logic [6:0] PAT_1     = 7'b0000110;
    localparam logic [6:0] PAT_2     = 7'b1011011;
    localparam logic [6:0] PAT_3     = 7'b1001111;
    localparam logic [6:0] PAT_4     = 7'b1100110;
    localparam logic [6:0] PAT_5     = 7'b1101101;
    localparam logic [6:0] PAT_6     = 7'b1111100;
    localparam logic [6:0] PAT_7     = 7'b0000111;
    localparam logic [6:0] PAT_8     = 7'b1111111;
    localparam logic [6:0] PAT_9     = 7'b1100111;
    localparam logic [6:0] PAT_BLANK = 7'b0000000;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    // Reader FSM: SYNC waits for a units frame; HAVE_UNIT holds a pending
    // units digit and waits for the matching tens frame.
    typedef enum logic {
        ST_SYNC      = 1'b0,
        ST_HAVE_UNIT = 1'b1
    } reader_state_t;

    typedef struct packed {
        logic       legal;
        logic [3:0] value;
    } seg_decode_t;

    // Maps a segment pattern to a digit code. The blank pattern is legal
    // and decodes to BLANK_CODE. Any other unknown pattern is illegal.
    function automatic seg_decode_t seg_decode(input logic [6:0] pat);
        seg_decode_t d;
        d.legal = 1'b1;
        d.value = 4'd0;
        case (pat)
            PAT_0:     d.value = 4'd0;
            PAT_1:     d.value = 4'd1;
            PAT_2:     d.value = 4'd2;
            PAT_3:     d.value = 4'd3;
            PAT_4:     d.value = 4'd4;
            PAT_5:     d.value = 4'd5;
            PAT_6:     d.value = 4'd6;
            PAT_7:     d.value = 4'd7;
            PAT_8:     d.value = 4'd8;
            PAT_9:     d.value = 4'd9;
            PAT_BLANK: d.value = BLANK_CODE;
            default: begin
                d.legal = 1'b0;
                d.value = 4'd0;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/seg_stable_filter.sv
// Input stability filter for the segment reader.
// It registers the raw segments and digit inputs once. It then counts how
// many consecutive cycles the registered pair has stayed the same. When the
// count first reaches STABLE_CYCLES, it emits a single-cycle accept.
// Ports:
//   clk, rst_n    - clock and async active-low reset
//   i_segments    - raw segment pattern (g..a)
//   i_digit       - raw digit select (0 = units, 1 = tens)
//   o_s_seg       - registered segment pattern
//   o_s_dig       - registered digit select
//   o_accept      - one-cycle pulse; the registered sample is now stable
module seg_stable_filter #(
    parameter int STABLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] i_segments,
    input  logic       i_digit,
    output logic [6:0] o_s_seg,
    output logic       o_s_dig,
    output logic       o_accept
);

    localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

    logic [6:0] r_s_seg;
    logic       r_s_dig;
    logic [3:0] r_run;
    logic       r_accept;

    logic       w_restart;
    logic [3:0] w_run_next;
    logic       w_accept_next;

    // A run restarts on the first sample after reset (run==0), or when the
    // incoming sample differs from the one currently held.
    always_comb begin
        w_restart = (r_run == 4'd0) || ({i_segments, i_digit} != {r_s_seg, r_s_dig});
        if (w_restart) begin
            w_run_next = 4'd1;
        end else if (r_run >= STABLE) begin
            w_run_next = STABLE;
        end else begin
            w_run_next = r_run + 4'd1;
        end
        // Fire only on the cycle the run arrives at STABLE. A saturated run
        // that is held stays silent. With STABLE=1, every restart fires.
        w_accept_next = (w_run_next == STABLE) && (w_restart || (r_run != STABLE));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_seg  <= 7'd0;
            r_s_dig  <= 1'b0;
            r_run    <= 4'd0;
            r_accept <= 1'b0;
        end else begin
            r_s_seg  <= i_segments;
            r_s_dig  <= i_digit;
            r_run    <= w_run_next;
            r_accept <= w_accept_next;
        end
    end

    assign o_s_seg  = r_s_seg;
    assign o_s_dig  = r_s_dig;
    assign o_accept = r_accept;

endmodule

// File: rtl/segment_reader.sv
// Multiplexed seven-segment reader.
// The block watches a two-digit display bus. It filters each frame for
// stability and decodes the pattern. It then pairs a units frame with the
// following tens frame and commits the pair.
// Ports:
//   clk, rst_n   - clock and async active-low reset
//   enable       - high = capture running; low = acceptance suppressed
//   segments     - multiplexed segment pattern (g..a)
//   digit        - 0 = units frame, 1 = tens frame
//   clear_error  - clears the sticky error flag
//   ten_count    - last committed tens value (4'hF = blank)
//   unit_count   - last committed units value (4'hF = blank)
//   valid        - one-cycle pulse when a pair commits
//   changed      - pulse with valid when the pair differs from the previous one
//   error        - sticky illegal-pattern flag
//   dbg_state    - current FSM state (0 = SYNC, 1 = HAVE_UNIT)
//
// Handshake: valid is a one-cycle strobe with no back-pressure. ten_count
// and unit_count are stable from the cycle valid is high until the next commit.
module segment_reader
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [6:0] segments,
    input  logic       digit,
    input  logic       clear_error,
    output logic [3:0] ten_count,
    output logic [3:0] unit_count,
    output logic       valid,
    output logic       changed,
    output logic       error,
    output logic       dbg_state
);

    logic [6:0]    w_s_seg;
    logic          w_s_dig;
    logic          w_accept_raw;
    logic          w_acc;
    seg_decode_t   w_dec;

    reader_state_t r_state;
    reader_state_t w_state_next;

    logic          w_store_unit;
    logic          w_commit;
    logic          w_set_err;
    logic          w_discard;

    logic [3:0]    r_pending;
    logic [3:0]    r_ten;
    logic [3:0]    r_unit;
    logic          r_valid;
    logic          r_changed;
    logic          r_error;
    logic          r_has_commit;

    seg_stable_filter #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_segments (segments),
        .i_digit    (digit),
        .o_s_seg    (w_s_seg),
        .o_s_dig    (w_s_dig),
        .o_accept   (w_accept_raw)
    );

    assign w_acc = w_accept_raw & enable;
    assign w_dec = seg_decode(w_s_seg);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        if (!enable) begin
            w_state_next = ST_SYNC;
        end else if (w_acc) begin
            if (!w_dec.legal) begin
                w_state_next = ST_SYNC;
            end else begin
                case (r_state)
                    ST_SYNC:      if (!w_s_dig) w_state_next = ST_HAVE_UNIT;
                    ST_HAVE_UNIT: if (w_s_dig)  w_state_next = ST_SYNC;
                    default:      w_state_next = ST_SYNC;
                endcase
            end
        end
    end

    // Output / action decode
    always_comb begin
        w_store_unit = 1'b0;
        w_commit     = 1'b0;
        w_set_err    = 1'b0;
        w_discard    = !enable;
        if (w_acc) begin
            if (!w_dec.legal) begin
                w_set_err = 1'b1;
                w_discard = 1'b1;
            end else begin
                case (r_state)
                    // A tens frame without a pending unit is simply dropped.
                    ST_SYNC: w_store_unit = !w_s_dig;
                    ST_HAVE_UNIT: begin
                        w_store_unit = !w_s_dig;
                        w_commit     = w_s_dig;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending    <= 4'd0;
            r_ten        <= 4'd0;
            r_unit       <= 4'd0;
            r_valid      <= 1'b0;
            r_changed    <= 1'b0;
            r_error      <= 1'b0;
            r_has_commit <= 1'b0;
        end else begin
            if (w_discard) begin
                r_pending <= 4'd0;
            end else if (w_store_unit) begin
                r_pending <= w_dec.value;
            end

            r_valid <= w_commit;
            // The first commit after reset always reports a change. This holds
            // even when the pair equals the 0/0 reset value.
            r_changed <= w_commit &&
                         (!r_has_commit || ({w_dec.value, r_pending} != {r_ten, r_unit}));
            if (w_commit) begin
                r_ten        <= w_dec.value;
                r_unit       <= r_pending;
                r_has_commit <= 1'b1;
            end

            // An illegal accept beats a same-cycle clear.
            if (w_set_err) begin
                r_error <= 1'b1;
            end else if (clear_error) begin
                r_error <= 1'b0;
            end
        end
    end

    assign ten_count  = r_ten;
    assign unit_count = r_unit;
    assign valid      = r_valid;
    assign changed    = r_changed;
    assign error      = r_error;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_segment_reader.sv
module tb_segment_reader;

  localparam logic [6:0] P0  = 7'b0111111;
  localparam logic [6:0] P1  = 7'b0000110;
  localparam logic [6:0] P2  = 7'b1011011;
  localparam logic [6:0] P3  = 7'b1001111;
  localparam logic [6:0] P4  = 7'b1100110;
  localparam logic [6:0] P5  = 7'b1101101;
  localparam logic [6:0] P7  = 7'b0000111;
  localparam logic [6:0] P8  = 7'b1111111;
  localparam logic [6:0] P9  = 7'b1100111;
  localparam logic [6:0] BAD = 7'b1010101;
  localparam logic [6:0] BLK = 7'b0000000;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [6:0] segments;
  logic       digit;
  logic       clear_error;

  logic [3:0] ten1, unit1, ten3, unit3;
  logic       valid1, changed1, error1, state1;
  logic       valid3, changed3, error3, state3;

  int checks;
  int failures;

  segment_reader #(.STABLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .segments(segments),
    .digit(digit), .clear_error(clear_error), .ten_count(ten1),
    .unit_count(unit1), .valid(valid1), .changed(changed1),
    .error(error1), .dbg_state(state1)
  );

  segment_reader #(.STABLE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .segments(segments),
    .digit(digit), .clear_error(clear_error), .ten_count(ten3),
    .unit_count(unit3), .valid(valid3), .changed(changed3),
    .error(error3), .dbg_state(state3)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one frame sample; returns at the next falling edge after it was clocked.
  task automatic drive(input logic [6:0] seg, input logic dig);
    segments = seg;
    digit    = dig;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    enable      = 1'b1;
    segments    = 7'd0;
    digit       = 1'b0;
    clear_error = 1'b0;
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_ten", ten1, 0);
    chk("rst_unit", unit1, 0);
    chk("rst_valid", valid1, 0);
    chk("rst_changed", changed1, 0);
    chk("rst_error", error1, 0);
    chk("rst_state", state1, 0);
    chk("rst_valid3", valid3, 0);
    rst_n = 1'b1;

    // first pair: units 1, tens 2
    drive(P1, 1'b0);
    chk("p1_valid_early", valid1, 0);
    drive(P2, 1'b1);
    chk("p1_state_have", state1, 1);
    chk("p1_valid_mid", valid1, 0);
    drive(P2, 1'b1);
    chk("p1_valid", valid1, 1);
    chk("p1_changed", changed1, 1);
    chk("p1_ten", ten1, 2);
    chk("p1_unit", unit1, 1);
    chk("p1_state_sync", state1, 0);
    drive(P2, 1'b1);
    chk("p1_valid_pulse", valid1, 0);
    chk("p1_changed_pulse", changed1, 0);

    // same pair again
    drive(P1, 1'b0);
    drive(P2, 1'b1);
    drive(P2, 1'b1);
    chk("p2_valid", valid1, 1);
    chk("p2_changed", changed1, 0);
    chk("p2_ten", ten1, 2);
    chk("p2_unit", unit1, 1);

    // illegal units pattern
    drive(BAD, 1'b0);
    drive(BAD, 1'b0);
    chk("bad_error", error1, 1);
    chk("bad_valid", valid1, 0);
    chk("bad_state", state1, 0);
    chk("bad_ten_hold", ten1, 2);
    drive(P3, 1'b0);
    drive(P7, 1'b1);
    drive(P7, 1'b1);
    chk("p3_valid", valid1, 1);
    chk("p3_changed", changed1, 1);
    chk("p3_ten", ten1, 7);
    chk("p3_unit", unit1, 3);
    chk("p3_error_sticky", error1, 1);
    clear_error = 1'b1;
    drive(P7, 1'b1);
    chk("clr_error", error1, 0);
    drive(BAD, 1'b0);
    chk("clr_error_hold", error1, 0);
    drive(BAD, 1'b0);
    chk("clr_vs_illegal", error1, 1);
    clear_error = 1'b0;

    // enable low discards the pending unit and ignores the accept
    drive(BLK, 1'b0);
    drive(P5, 1'b0);
    chk("en_state_have", state1, 1);
    enable = 1'b0;
    drive(P1, 1'b1);
    chk("en_state_sync", state1, 0);
    chk("en_valid_a", valid1, 0);
    enable = 1'b1;
    drive(P1, 1'b1);
    chk("en_valid_b", valid1, 0);
    chk("en_state_b", state1, 0);
    drive(P1, 1'b1);
    chk("en_valid_c", valid1, 0);
    chk("en_ten_hold", ten1, 7);
    chk("en_unit_hold", unit1, 3);

    // asynchronous reset
    rst_n = 1'b0;
    #1;
    chk("arst_ten", ten1, 0);
    chk("arst_unit", unit1, 0);
    chk("arst_error", error1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // STABLE_CYCLES=3 with a one-cycle glitch
    drive(P0, 1'b0);
    drive(P8, 1'b0);
    drive(P0, 1'b0);
    chk("glitch_state_a", state3, 0);
    drive(P0, 1'b0);
    chk("glitch_state_b", state3, 0);
    drive(P0, 1'b0);
    chk("s3_state_pre", state3, 0);
    chk("s3_error", error3, 0);
    drive(P0, 1'b1);
    chk("s3_state_have", state3, 1);
    drive(P0, 1'b1);
    chk("s3_valid_k1", valid3, 0);
    drive(P0, 1'b1);
    chk("s3_valid_k2", valid3, 0);
    drive(P0, 1'b1);
    chk("s3_valid", valid3, 1);
    chk("s3_changed", changed3, 1);
    chk("s3_ten", ten3, 0);
    chk("s3_unit", unit3, 0);

    // blank tens with units 5
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(P5, 1'b0);
    drive(BLK, 1'b1);
    drive(BLK, 1'b1);
    chk("blk_valid", valid1, 1);
    chk("blk_ten", ten1, 4'hF);
    chk("blk_unit", unit1, 5);
    chk("blk_changed", changed1, 1);

    // reset mid-pair
    drive(P9, 1'b0);
    drive(P9, 1'b0);
    chk("mid_state_have", state1, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_ten", ten1, 0);
    chk("mid_unit", unit1, 0);
    chk("mid_valid", valid1, 0);
    chk("mid_changed", changed1, 0);
    chk("mid_error", error1, 0);
    chk("mid_state", state1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(P1, 1'b1);
      chk("mid_no_valid", valid1, 0);
      chk("mid_ten_zero", ten1, 0);
    end

    // digit toggling every cycle
    drive(P2, 1'b0);
    drive(P3, 1'b1);
    drive(P4, 1'b0);
    chk("tog_valid_a", valid1, 1);
    chk("tog_ten_a", ten1, 3);
    chk("tog_unit_a", unit1, 2);
    drive(P5, 1'b1);
    chk("tog_valid_gap", valid1, 0);
    drive(P1, 1'b0);
    chk("tog_valid_b", valid1, 1);
    chk("tog_ten_b", ten1, 5);
    chk("tog_unit_b", unit1, 4);
    chk("tog_changed_b", changed1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/segment_reader.md
SEGMENT_READER -- requirements
Module: segment_reader

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 1, range 1..15: consecutive identical samples needed before a frame is accepted.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port enable  input  1  high = capture running; low = acceptance suppressed.
REQ-005 SHALL have port segments  input  7  multiplexed pattern; bit6..bit0 = segments g..a.
REQ-006 SHALL have port digit  input  1  digit select; 0 = units frame, 1 = tens frame.
REQ-007 SHALL have port clear_error  input  1  clears the sticky error flag.
REQ-008 SHALL have port ten_count  output  4  last committed tens value (4'hF = blank).
REQ-009 SHALL have port unit_count  output  4  last committed units value (4'hF = blank).
REQ-010 SHALL have port valid  output  1  one-cycle pulse when a new pair commits.
REQ-011 SHALL have port changed  output  1  one-cycle pulse, coincident with valid, when the pair differs from the previous commit.
REQ-012 SHALL have port error  output  1  sticky flag for an illegal pattern.

Function
REQ-013 SHALL register segments and digit once (s_seg, s_dig) before any decoding.
REQ-014 SHALL keep run counter run (saturating at STABLE_CYCLES): run=1 when run==0 or {s_seg,s_dig} differs from previous cycle, else run+1.
REQ-015 SHALL raise internal accept for exactly one cycle when run reaches STABLE_CYCLES; no re-accept until the sampled value changes.
REQ-016 SHALL decode: 0111111->0, 0000110->1, 1011011->2, 1001111->3, 1100110->4, 1101101->5, 1111100->6, 0000111->7, 1111111->8, 1100111->9, 0000000->4'hF (blank); any other pattern is illegal.
REQ-017 SHALL implement FSM with states SYNC and HAVE_UNIT.
REQ-018 SYNC: accept with s_dig=0 and legal pattern -> store pending unit, go HAVE_UNIT; accept with s_dig=1 -> ignored.
REQ-019 HAVE_UNIT: accept with s_dig=1 and legal pattern -> commit ten_count/unit_count, pulse valid, go SYNC; accept with s_dig=0 -> overwrite pending unit, stay HAVE_UNIT.
REQ-020 Accept of an illegal pattern in any state SHALL set error, discard the pending unit, and force SYNC; committed outputs unchanged.
REQ-021 changed SHALL assert with valid when the committed pair differs from the prior commit; the first commit after reset SHALL always assert changed.
REQ-022 Latency: if edge k is the first edge sampling a tens frame, valid SHALL be high in the cycle after edge k+STABLE_CYCLES.
REQ-023 enable low SHALL suppress accept, hold the FSM in SYNC, discard the pending unit and hold all outputs; run keeps counting.
REQ-024 clear_error SHALL clear error on the next edge; a simultaneous illegal accept SHALL win (error stays 1).
REQ-025 With STABLE_CYCLES=1 and digit toggling every cycle, every frame SHALL be accepted and a pair committed every two cycles.

Reset
REQ-026 rst_n low SHALL asynchronously clear: ten_count=0, unit_count=0, valid=0, changed=0, error=0, run=0, s_seg=0, s_dig=0, FSM=SYNC, pending unit=0.
REQ-027 The first sample after reset release SHALL start a new run (run=1) regardless of its value.
REQ-028 Reset asserted mid-pair SHALL discard the pending unit with no valid pulse.

Structure
REQ-029 Shared package seg_pkg SHALL hold the ten digit patterns, the blank pattern, BLANK_CODE=4'hF and FSM state encodings, shared with the display driver.
REQ-030 The stability filter (input register, run counter, accept) SHALL be a sub-module seg_stable_filter; decode and FSM stay in segment_reader.

Verification
REQ-031 Drive units 0000110, then tens 1011011, STABLE_CYCLES=1 -> ten_count=2, unit_count=1, valid and changed one cycle.
REQ-032 Repeat the same pair -> valid pulses, changed stays 0, counts unchanged.
REQ-033 Inject 1010101 in a units frame -> error=1, no valid; next good pair commits; clear_error -> error=0.
REQ-034 STABLE_CYCLES=3, a one-cycle glitch 1111111 inside a held 0111111 frame -> glitch never accepted, 0 commits after three stable cycles.
REQ-035 Blank tens 0000000 with units 5 -> ten_count=4'hF, unit_count=5; rst_n low after units frame only -> no valid, all outputs 0.
